reg_write_arbiter: RTL

- Round-robin arbiter that shares one W-bit write-enabled register among N requesters in the multicycle datapath.
- Each cycle it picks at most one requester, writes that requester's data into the shared register and reports the winner.
- A requester may hold the port for back-to-back writes with a lock request; a lock counter bounds how long it can hold the port, so other requesters are not starved.
- Sits between datapath sources (ALU result, memory data, immediate path, etc.) and the shared destination register.

---
 rtl/reg_write_arbiter.sv | 109 ++++++++++
 1 files changed

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter
// Round-robin arbiter in front of one shared W-bit destination register.
// Each cycle at most one requester wins; its data slice is written into the
// register and the winner is reported. The previous winner may keep the port
// with a lock request. A lock counter bounds how long it can do that while
// other requesters are waiting.
//
// Ports:
//   i_clk     rising-edge clock
//   i_rst_n   asynchronous active-low reset
//   i_req     [N]    per-requester write request
//   i_lock    [N]    keep-grant request, only meaningful for the last winner
//   i_data    [N*W]  packed data, requester i at [i*W +: W]
//   o_q       [W]    shared register contents
//   o_grant   [N]    registered one-hot winner of the last edge (0 if idle)
//   o_valid          o_q was written on the last edge
//   o_src     [SW]   index of the last winner, holds while idle
module reg_write_arbiter #(
    parameter int N       = 4,
    parameter int W       = 8,
    parameter int MAXLOCK = 3,
    localparam int SW     = (N > 1) ? $clog2(N) : 1
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic [N-1:0]   i_req,
    input  logic [N-1:0]   i_lock,
    input  logic [N*W-1:0] i_data,
    output logic [W-1:0]   o_q,
    output logic [N-1:0]   o_grant,
    output logic           o_valid,
    output logic [SW-1:0]  o_src
);

    localparam int CW = $clog2(MAXLOCK + 1);
    localparam logic [CW-1:0] MAXLOCK_C = CW'(MAXLOCK);
    localparam logic [N-1:0]  ONE_N     = N'(1);

    logic [W-1:0]  r_q;
    logic [N-1:0]  r_grant;
    logic          r_valid;
    logic [SW-1:0] r_src;
    logic [SW-1:0] r_ptr;
    logic [CW-1:0] r_lockcnt;

    logic          w_others;
    logic          w_cont;
    logic          w_rr_found;
    logic [SW-1:0] w_rr_idx;
    logic [SW-1:0] w_sel;
    logic [CW-1:0] w_cnt_next;

    // Lock continuation: only the previous winner can keep the port, and only
    // while under the lock budget unless nobody else is asking.
    always_comb begin
        w_others = |(i_req & ~(ONE_N << r_src));
        w_cont   = r_grant[r_src] && i_req[r_src] && i_lock[r_src] &&
                   ((r_lockcnt < MAXLOCK_C) || !w_others);
    end

    // Round-robin search starting just after the last winner.
    always_comb begin
        w_rr_found = 1'b0;
        w_rr_idx   = '0;
        for (int k = 1; k <= N; k++) begin
            if (!w_rr_found && i_req[(int'(r_ptr) + k) % N]) begin
                w_rr_found = 1'b1;
                w_rr_idx   = SW'((int'(r_ptr) + k) % N);
            end
        end
    end

    always_comb begin
        w_sel      = w_cont ? r_src : w_rr_idx;
        w_cnt_next = CW'(1);
        if (w_cont) begin
            w_cnt_next = (r_lockcnt == MAXLOCK_C) ? MAXLOCK_C : r_lockcnt + CW'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q       <= '0;
            r_grant   <= '0;
            r_valid   <= 1'b0;
            r_src     <= '0;
            r_ptr     <= SW'(N - 1);
            r_lockcnt <= '0;
        end else if (|i_req) begin
            r_q       <= i_data[int'(w_sel)*W +: W];
            r_grant   <= ONE_N << w_sel;
            r_valid   <= 1'b1;
            r_src     <= w_sel;
            r_ptr     <= w_sel;
            r_lockcnt <= w_cnt_next;
        end else begin
            // Idle cycle: data and winner index hold, any lock is broken.
            r_grant   <= '0;
            r_valid   <= 1'b0;
            r_lockcnt <= '0;
        end
    end

    assign o_q     = r_q;
    assign o_grant = r_grant;
    assign o_valid = r_valid;
    assign o_src   = r_src;

endmodule
